// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller
// Brief    : Scans four 4-bit digit codes onto one shared decoder with
//            active-low digit enables, frame-synchronous double buffering,
//            blanking of non-digit codes, leading-zero suppression and an
//            "Erro" override. Define DISPLAY_BLINK_EN to blink the error word.
// Revision : 1.0  initial release
// ============================================================================
module display_scan_controller #(
    parameter int SCAN_DIV     = 4,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] values,
    input  logic        load,
    input  logic        error,
    input  logic        lz_blank,
    output logic [3:0]  data,
    output logic [3:0]  digit_n,
    output logic        frame,
    output logic        pending
);

    localparam int            c_cnt_w    = $clog2(SCAN_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_dead     = c_cnt_w'(DEAD);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nx;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nx;
    logic [15:0]        r_shadow;
    logic [15:0]        w_shadow_nx;
    logic [15:0]        r_pend_buf;
    logic [15:0]        w_pend_buf_nx;
    logic               r_err;
    logic               w_err_nx;
    logic               r_run;
    logic               w_pending_nx;
    logic               w_slot_end;
    logic               w_boundary;
    logic [3:0]         w_code;
    logic               w_code_sup;
    logic               w_lz_sup;
    logic               w_blank_frame;
    logic [3:0]         w_digit_n_nx;
    logic               w_frame_nx;

    // r_run holds the counters for one edge after reset so the first cycle
    // out of reset is presented as slot 0 / cnt 0 with a frame pulse.
    always_comb begin
        w_slot_end    = r_run && (r_cnt == c_cnt_last);
        w_boundary    = w_slot_end && (r_idx == 2'd3);
        w_cnt_nx      = r_cnt;
        w_idx_nx      = r_idx;
        if (w_slot_end) begin
            w_cnt_nx = '0;
            w_idx_nx = r_idx + 2'd1;
        end else if (r_run) begin
            w_cnt_nx = r_cnt + c_cnt_w'(1);
        end
        // The boundary uses the buffer as it was before any same-cycle load.
        w_shadow_nx   = (w_boundary && pending) ? r_pend_buf : r_shadow;
        w_err_nx      = w_boundary ? error : r_err;
        w_pend_buf_nx = load ? values : r_pend_buf;
        w_pending_nx  = load | (pending & ~w_boundary);
    end

`ifdef DISPLAY_BLINK_EN
    localparam int                   c_blink_w    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic [c_blink_w-1:0] w_blink_cnt_nx;
    logic                 r_blink_off;
    logic                 w_blink_off_nx;

    // Held cleared while no error is latched, so the first error frame is lit.
    always_comb begin
        w_blink_cnt_nx = r_blink_cnt;
        w_blink_off_nx = r_blink_off;
        if (!w_err_nx) begin
            w_blink_cnt_nx = '0;
            w_blink_off_nx = 1'b0;
        end else if (w_boundary && r_err) begin
            if (r_blink_cnt == c_blink_last) begin
                w_blink_cnt_nx = '0;
                w_blink_off_nx = ~r_blink_off;
            end else begin
                w_blink_cnt_nx = r_blink_cnt + c_blink_w'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nx;
            r_blink_off <= w_blink_off_nx;
        end
    end

    assign w_blank_frame = w_blink_off_nx;
`else
    assign w_blank_frame = 1'b0;
`endif

    // Outputs are computed from next-state values so the registered outputs
    // line up with the counters without an extra cycle of latency.
    always_comb begin
        w_code = w_shadow_nx[{w_idx_nx, 2'b00} +: 4];
        if (w_err_nx) begin
            case (w_idx_nx)
                2'd0:    w_code = 4'b1111;
                2'd1:    w_code = 4'b1110;
                2'd2:    w_code = 4'b1110;
                default: w_code = 4'b1100;
            endcase
        end
        w_code_sup = !w_err_nx &&
                     ((w_code == 4'b1010) || (w_code == 4'b1011) || (w_code == 4'b1101));
        case (w_idx_nx)
            2'd1:    w_lz_sup = (w_shadow_nx[15:4]  == 12'h000);
            2'd2:    w_lz_sup = (w_shadow_nx[15:8]  == 8'h00);
            2'd3:    w_lz_sup = (w_shadow_nx[15:12] == 4'h0);
            default: w_lz_sup = 1'b0;
        endcase
        w_lz_sup = w_lz_sup && lz_blank && !w_err_nx;
        if ((w_cnt_nx < c_dead) || w_code_sup || w_lz_sup || w_blank_frame) begin
            w_digit_n_nx = 4'b1111;
        end else begin
            w_digit_n_nx = ~(4'b0001 << w_idx_nx);
        end
        w_frame_nx = w_boundary || !r_run;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_shadow   <= 16'h0000;
            r_pend_buf <= 16'h0000;
            r_err      <= 1'b0;
            r_run      <= 1'b0;
            pending    <= 1'b0;
            data       <= 4'b0000;
            digit_n    <= 4'b1111;
            frame      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_shadow   <= w_shadow_nx;
            r_pend_buf <= w_pend_buf_nx;
            r_err      <= w_err_nx;
            r_run      <= 1'b1;
            pending    <= w_pending_nx;
            data       <= w_code;
            digit_n    <= w_digit_n_nx;
            frame      <= w_frame_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// Bench for display_scan_controller: frame-level reference model feeding a
// queue of per-cycle expectations, drained and compared by a monitor.
module tb_display_scan_controller;

    localparam int SCAN_DIV     = 4;
    localparam int DEAD         = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * SCAN_DIV;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] dn;
        logic       fr;
        logic       pe;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] values = 16'h0000;
    logic        load = 1'b0;
    logic        error = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  data;
    logic [3:0]  digit_n;
    logic        frame;
    logic        pending;

    display_scan_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .DEAD         (DEAD),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .values   (values),
        .load     (load),
        .error    (error),
        .lz_blank (lz_blank),
        .data     (data),
        .digit_n  (digit_n),
        .frame    (frame),
        .pending  (pending)
    );

    always #5 clock = ~clock;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Level inputs applied on the next driven cycle.
    logic nx_rst = 1'b0;
    logic nx_err = 1'b0;
    logic nx_lz  = 1'b0;

    // Reference model state: position within the frame plus the buffers.
    int          m_pos = 0;
    bit          m_started = 1'b0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_pbuf = 16'h0000;
    bit          m_pend = 1'b0;
    bit          m_err = 1'b0;
    int          m_errfr = 0;
    logic [3:0]  err_word [4] = '{4'b1111, 4'b1110, 4'b1110, 4'b1100};

    task automatic model_edge();
        exp_t        e;
        int          slot;
        int          sub;
        logic [15:0] upper;
        logic [3:0]  code;
        bit          bnd;
        bit          prev_started;
        bit          prev_err;
        bit          supp;
        bit          dark;
        if (!reset_n) begin
            m_pos = 0; m_started = 0; m_shadow = '0; m_pbuf = '0;
            m_pend = 0; m_err = 0; m_errfr = 0;
            e.data = 4'h0; e.dn = 4'hF; e.fr = 1'b0; e.pe = 1'b0;
        end else begin
            bnd = m_started && (m_pos == FRAME - 1);
            prev_started = m_started;
            if (m_started) m_pos = (m_pos + 1) % FRAME;
            if (bnd) begin
                if (m_pend) begin
                    m_shadow = m_pbuf;
                    m_pend = 0;
                end
                prev_err = m_err;
                m_err = error;
                m_errfr = (m_err && prev_err) ? m_errfr + 1 : 0;
            end
            if (load) begin
                m_pbuf = values;
                m_pend = 1;
            end
            m_started = 1;
            slot  = m_pos / SCAN_DIV;
            sub   = m_pos % SCAN_DIV;
            upper = m_shadow >> (4 * slot);
            code  = m_err ? err_word[slot] : upper[3:0];
            supp  = !m_err && (code == 4'hA || code == 4'hB || code == 4'hD);
            if (lz_blank && !m_err && slot >= 1 && upper == 16'h0000) supp = 1;
            dark = 0;
`ifdef DISPLAY_BLINK_EN
            if (m_err && ((m_errfr / BLINK_FRAMES) % 2 == 1)) dark = 1;
`endif
            e.data = code;
            e.dn   = (sub < DEAD || supp || dark) ? 4'hF : ~(4'b0001 << slot);
            e.fr   = !prev_started || bnd;
            e.pe   = m_pend;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic ld, input logic [15:0] v);
        @(negedge clock);
        reset_n  = nx_rst;
        error    = nx_err;
        lz_blank = nx_lz;
        load     = ld;
        values   = v;
        model_edge();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 16'h0000);
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < FRAME + 2 && m_pos != p; k++) cyc(1'b0, 16'h0000);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'h0000;
        for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 1) == 1) r[4*k +: 4] = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("data", data, e.data);
            chk("digit_n", digit_n, e.dn);
            chk("frame", {3'b000, frame}, {3'b000, e.fr});
            chk("pending", {3'b000, pending}, {3'b000, e.pe});
        end
    end

    initial begin
        // Reset and scan
        run(3);
        nx_rst = 1'b1;
        cyc(1'b1, 16'h1234);
        run(3 * FRAME);
        // Double buffer: last load before the boundary wins
        wait_pos(2);
        cyc(1'b1, 16'h0042);
        run(3);
        cyc(1'b1, 16'h0099);
        run(2 * FRAME);
        // Load landing in the boundary cycle
        wait_pos(3);
        cyc(1'b1, 16'h1111);
        wait_pos(FRAME - 1);
        cyc(1'b1, 16'h2222);
        run(3 * FRAME);
        // Leading zeros and non-digit codes
        nx_lz = 1'b1;
        cyc(1'b1, 16'h0007);
        run(2 * FRAME);
        cyc(1'b1, 16'h0000);
        run(2 * FRAME);
        cyc(1'b1, 16'h0AD5);
        run(2 * FRAME);
        nx_lz = 1'b0;
        cyc(1'b1, 16'hB0D1);
        run(2 * FRAME);
        // Error held across a boundary
        cyc(1'b1, 16'h1234);
        run(FRAME);
        wait_pos(FRAME - 10);
        nx_err = 1'b1;
        run(20);
        nx_err = 1'b0;
        run(3 * FRAME);
        // Short error pulse between boundaries is ignored
        wait_pos(2);
        nx_err = 1'b1;
        run(5);
        nx_err = 1'b0;
        run(2 * FRAME);
        // Long error hold
        nx_err = 1'b1;
        run(7 * FRAME);
        nx_err = 1'b0;
        run(2 * FRAME);
        // Reset in slot 2 with a queued load
        wait_pos(5);
        cyc(1'b1, 16'h5678);
        wait_pos(2 * SCAN_DIV + 1);
        nx_rst = 1'b0;
        run(2);
        nx_rst = 1'b1;
        run(2 * FRAME);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) nx_err = ~nx_err;
            if ($urandom_range(0, 99) == 0) nx_lz = ~nx_lz;
            nx_rst = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 7) == 0), rand_val());
        end
        nx_rst = 1'b1;
        run(FRAME);
        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: actual=%0d expected=0 entries left", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
